// File: rtl/mac_feed_ctrl.sv
// mac_feed_ctrl
//   Upstream sequencer for the MAC array. It walks every beat of a frame in the order
//   pixel -> output-channel group -> input-channel beat, issuing one read per cycle to
//   the fmap and param buffers. Read-side strobes are then pushed through two delay
//   lines. The first models the buffer read latency and produces the MAC input valid
//   and the accumulator clear. The second models the MAC pipeline and produces the
//   output-valid strobe together with the pixel/group tags of each finished result.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start           one-cycle frame request, only honoured in IDLE
//   busy, done      frame in progress / one-cycle completion pulse
//   fmap_rd_en      fmap buffer read enable; fmap_rd_addr = pixel*DATA_BEATS + beat
//   param_rd_en     param buffer read enable; param_rd_addr = group*DATA_BEATS + beat
//   mac_in_valid    MAC data/param input valid
//   mac_adder_rst   MAC accumulator clear, coincides with beat 0 at the MAC input
//   mac_out_valid   MAC output holds a finished result
//   out_pixel       pixel tag of the finished result
//   out_group       group tag of the finished result
module mac_feed_ctrl #(
    parameter int DATA_BEATS  = 4,
    parameter int OC_GROUPS   = 5,
    parameter int PIXELS      = 1024,
    parameter int RD_LAT      = 1,
    parameter int MAC_LATENCY = 10,
    parameter int FMAP_AW     = 12,
    parameter int PARAM_AW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                fmap_rd_en,
    output logic [FMAP_AW-1:0]  fmap_rd_addr,
    output logic                param_rd_en,
    output logic [PARAM_AW-1:0] param_rd_addr,
    output logic                mac_in_valid,
    output logic                mac_adder_rst,
    output logic                mac_out_valid,
    output logic [15:0]         out_pixel,
    output logic [7:0]          out_group
);

    localparam int BEAT_W  = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam int GRP_W   = (OC_GROUPS > 1) ? $clog2(OC_GROUPS) : 1;
    localparam int PIX_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int DRAIN_W = $clog2(RD_LAT + MAC_LATENCY + 1);

    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(DATA_BEATS - 1);
    localparam logic [GRP_W-1:0]    LAST_GRP   = GRP_W'(OC_GROUPS - 1);
    localparam logic [PIX_W-1:0]    LAST_PIX   = PIX_W'(PIXELS - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(RD_LAT + MAC_LATENCY - 1);
    localparam logic [FMAP_AW-1:0]  DB_F       = FMAP_AW'(DATA_BEATS);
    localparam logic [PARAM_AW-1:0] DB_P       = PARAM_AW'(DATA_BEATS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat, nxt_beat;
    logic [GRP_W-1:0]    grp, nxt_grp;
    logic [PIX_W-1:0]    pix, nxt_pix;
    logic                frame_last;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                rd_en;
    logic                iss_first;
    logic                iss_last;

    // Read-latency delay line: valid, beat-0 flag, last-beat flag and tags.
    logic                rl_valid [RD_LAT];
    logic                rl_first [RD_LAT];
    logic                rl_last  [RD_LAT];
    logic [PIX_W-1:0]    rl_pix   [RD_LAT];
    logic [GRP_W-1:0]    rl_grp   [RD_LAT];

    // MAC-latency delay line: only results (last beats) travel as valid.
    logic                ml_valid [MAC_LATENCY];
    logic [PIX_W-1:0]    ml_pix   [MAC_LATENCY];
    logic [GRP_W-1:0]    ml_grp   [MAC_LATENCY];

    // The counters hold the beat currently being issued; this works out the one after
    // it, so the registered addresses can be loaded in the same cycle the counters step.
    always_comb begin
        nxt_beat = beat;
        nxt_grp  = grp;
        nxt_pix  = pix;
        if (beat == LAST_BEAT) begin
            nxt_beat = '0;
            if (grp == LAST_GRP) begin
                nxt_grp = '0;
                nxt_pix = pix + PIX_W'(1);
            end else begin
                nxt_grp = grp + GRP_W'(1);
            end
        end else begin
            nxt_beat = beat + BEAT_W'(1);
        end
        frame_last = (beat == LAST_BEAT) && (grp == LAST_GRP) && (pix == LAST_PIX);
    end

    // Frame sequencer. Addresses are registered and only change while a beat is
    // issued, so they hold their last value through DRAIN and IDLE. DRAIN simply
    // counts out the two delay lines, which have no back-pressure and a fixed depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            grp           <= '0;
            pix           <= '0;
            drain_cnt     <= '0;
            rd_en         <= 1'b0;
            iss_first     <= 1'b0;
            iss_last      <= 1'b0;
            fmap_rd_addr  <= '0;
            param_rd_addr <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        beat          <= '0;
                        grp           <= '0;
                        pix           <= '0;
                        rd_en         <= 1'b1;
                        iss_first     <= 1'b1;
                        iss_last      <= (DATA_BEATS == 1);
                        fmap_rd_addr  <= '0;
                        param_rd_addr <= '0;
                    end
                end
                RUN: begin
                    if (frame_last) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                        iss_first <= 1'b0;
                        iss_last  <= 1'b0;
                    end else begin
                        beat          <= nxt_beat;
                        grp           <= nxt_grp;
                        pix           <= nxt_pix;
                        iss_first     <= (nxt_beat == '0);
                        iss_last      <= (nxt_beat == LAST_BEAT);
                        fmap_rd_addr  <= FMAP_AW'(nxt_pix) * DB_F + FMAP_AW'(nxt_beat);
                        param_rd_addr <= PARAM_AW'(nxt_grp) * DB_P + PARAM_AW'(nxt_beat);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both delay lines as plain shift registers. Stage 0 of the read line captures the
    // issue-side strobes; stage 0 of the MAC line captures results entering the MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                rl_valid[k] <= 1'b0;
                rl_first[k] <= 1'b0;
                rl_last[k]  <= 1'b0;
                rl_pix[k]   <= '0;
                rl_grp[k]   <= '0;
            end
            for (int k = 0; k < MAC_LATENCY; k++) begin
                ml_valid[k] <= 1'b0;
                ml_pix[k]   <= '0;
                ml_grp[k]   <= '0;
            end
        end else begin
            rl_valid[0] <= rd_en;
            rl_first[0] <= rd_en && iss_first;
            rl_last[0]  <= rd_en && iss_last;
            rl_pix[0]   <= pix;
            rl_grp[0]   <= grp;
            for (int k = 1; k < RD_LAT; k++) begin
                rl_valid[k] <= rl_valid[k-1];
                rl_first[k] <= rl_first[k-1];
                rl_last[k]  <= rl_last[k-1];
                rl_pix[k]   <= rl_pix[k-1];
                rl_grp[k]   <= rl_grp[k-1];
            end
            ml_valid[0] <= rl_valid[RD_LAT-1] && rl_last[RD_LAT-1];
            ml_pix[0]   <= rl_pix[RD_LAT-1];
            ml_grp[0]   <= rl_grp[RD_LAT-1];
            for (int k = 1; k < MAC_LATENCY; k++) begin
                ml_valid[k] <= ml_valid[k-1];
                ml_pix[k]   <= ml_pix[k-1];
                ml_grp[k]   <= ml_grp[k-1];
            end
        end
    end

    assign busy          = (state != IDLE);
    assign fmap_rd_en    = rd_en;
    assign param_rd_en   = rd_en;
    assign mac_in_valid  = rl_valid[RD_LAT-1];
    assign mac_adder_rst = rl_first[RD_LAT-1];
    assign mac_out_valid = ml_valid[MAC_LATENCY-1];
    assign out_pixel     = 16'(ml_pix[MAC_LATENCY-1]);
    assign out_group     = 8'(ml_grp[MAC_LATENCY-1]);

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// tb_mac_feed_ctrl
//   Self-checking bench for mac_feed_ctrl. Two instances: A with the default frame
//   geometry, B with a tiny one-beat geometry. Expected outputs for every cycle of a
//   frame come from an arithmetic model indexed by the cycle number since start.
module tb_mac_feed_ctrl;

    localparam int DBA = 4, OCA = 5, PXA = 1024, RLA = 1, MLA = 10;
    localparam int DBB = 1, OCB = 2, PXB = 3, RLB = 1, MLB = 10;
    localparam int NA  = DBA * OCA * PXA;
    localparam int NB  = DBB * OCB * PXB;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic        param_en;
        logic [11:0] fmap;
        logic [4:0]  param;
        logic        in_valid;
        logic        adder_rst;
        logic        out_valid;
        logic [15:0] out_pixel;
        logic [7:0]  out_group;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_a, start_a, rst_b, start_b;

    logic        busy_a, done_a, fen_a, pen_a, iv_a, ar_a, ov_a;
    logic [11:0] faddr_a;
    logic [4:0]  paddr_a;
    logic [15:0] opix_a;
    logic [7:0]  ogrp_a;

    logic        busy_b, done_b, fen_b, pen_b, iv_b, ar_b, ov_b;
    logic [11:0] faddr_b;
    logic [4:0]  paddr_b;
    logic [15:0] opix_b;
    logic [7:0]  ogrp_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_feed_ctrl #(
        .DATA_BEATS(DBA), .OC_GROUPS(OCA), .PIXELS(PXA), .RD_LAT(RLA),
        .MAC_LATENCY(MLA), .FMAP_AW(12), .PARAM_AW(5)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .fmap_rd_en(fen_a), .fmap_rd_addr(faddr_a),
        .param_rd_en(pen_a), .param_rd_addr(paddr_a),
        .mac_in_valid(iv_a), .mac_adder_rst(ar_a), .mac_out_valid(ov_a),
        .out_pixel(opix_a), .out_group(ogrp_a)
    );

    mac_feed_ctrl #(
        .DATA_BEATS(DBB), .OC_GROUPS(OCB), .PIXELS(PXB), .RD_LAT(RLB),
        .MAC_LATENCY(MLB), .FMAP_AW(12), .PARAM_AW(5)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .fmap_rd_en(fen_b), .fmap_rd_addr(faddr_b),
        .param_rd_en(pen_b), .param_rd_addr(paddr_b),
        .mac_in_valid(iv_b), .mac_adder_rst(ar_b), .mac_out_valid(ov_b),
        .out_pixel(opix_b), .out_group(ogrp_b)
    );

    function automatic obs_t obs_a();
        obs_t o;
        o = '{busy_a, done_a, fen_a, pen_a, faddr_a, paddr_a, iv_a, ar_a, ov_a, opix_a, ogrp_a};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{busy_b, done_b, fen_b, pen_b, faddr_b, paddr_b, iv_b, ar_b, ov_b, opix_b, ogrp_b};
        return o;
    endfunction

    // Expected outputs in cycle c, where start was sampled in cycle 0. Beat i (0-based)
    // is read in cycle i+1; its pixel/group/beat follow from plain division.
    function automatic obs_t model(int c, int db, int oc, int px, int rl, int ml);
        obs_t e;
        int   n, i, k, j;
        e = '0;
        n = db * oc * px;
        e.busy     = (c >= 1) && (c <= n + rl + ml);
        e.done     = (c == n + rl + ml + 1);
        e.rd_en    = (c >= 1) && (c <= n);
        e.param_en = e.rd_en;
        i = (c < 1) ? 0 : ((c > n) ? n - 1 : c - 1);
        e.fmap  = 12'((i / (oc * db)) * db + i % db);
        e.param = 5'(((i / db) % oc) * db + i % db);
        k = c - rl;
        e.in_valid  = (k >= 1) && (k <= n);
        e.adder_rst = e.in_valid && (((k - 1) % db) == 0);
        j = c - rl - ml;
        if ((j >= 1) && (j <= n) && (((j - 1) % db) == db - 1)) begin
            e.out_valid = 1'b1;
            e.out_pixel = 16'((j - 1) / (oc * db));
            e.out_group = 8'(((j - 1) / db) % oc);
        end
        return e;
    endfunction

    task automatic test_reset();
        obs_t a, b;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        a = obs_a(); b = obs_b();
        checks++;
        if (a !== '0) begin errors++; $display("[TB] FAIL reset_a got %h expected 0", a); end
        checks++;
        if (b !== '0) begin errors++; $display("[TB] FAIL reset_b got %h expected 0", b); end
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            a = obs_a();
            checks++;
            if (a !== '0) begin errors++; $display("[TB] FAIL idle_after_reset got %h expected 0", a); end
        end
    endtask

    task automatic test_full_frame();
        obs_t a, e;
        bit   bad = 1'b0;
        int   rd_cnt = 0, out_cnt = 0, done_cnt = 0, done_at = -1;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= NA + RLA + MLA + 4; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            a = obs_a();
            e = model(c, DBA, OCA, PXA, RLA, MLA);
            if (!e.out_valid) begin a.out_pixel = '0; a.out_group = '0; end
            rd_cnt  += int'(a.rd_en);
            out_cnt += int'(a.out_valid);
            if (a.done) begin done_cnt++; done_at = c; end
            if (!bad) begin
                checks++;
                if (a !== e) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL frame_cycle %0d got %h expected %h", c, a, e);
                end
            end
            if (c == NA) begin
                checks++;
                if (a.fmap !== 12'd4095 || a.param !== 5'd19) begin
                    errors++;
                    $display("[TB] FAIL last_addr got fmap=%0d param=%0d expected 4095/19", a.fmap, a.param);
                end
            end
        end
        checks++;
        if (rd_cnt != 20480) begin errors++; $display("[TB] FAIL rd_en_count got %0d expected 20480", rd_cnt); end
        checks++;
        if (out_cnt != 5120) begin errors++; $display("[TB] FAIL out_count got %0d expected 5120", out_cnt); end
        checks++;
        if (done_cnt != 1 || done_at != 20492) begin
            errors++;
            $display("[TB] FAIL done_timing got %0d pulses at %0d expected 1 at 20492", done_cnt, done_at);
        end
    endtask

    task automatic test_start_ignored();
        obs_t a, e;
        bit   bad = 1'b0;
        int   done_cnt = 0, done_at = -1;
        int   spur;
        spur = $urandom_range(200, NA + RLA + MLA);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= NA + RLA + MLA + 4; c++) begin
            @(negedge clk);
            a = obs_a();
            e = model(c, DBA, OCA, PXA, RLA, MLA);
            start_a = (c == 5) || (c == 100) || (c == spur);
            if (!e.out_valid) begin a.out_pixel = '0; a.out_group = '0; end
            if (a.done) begin done_cnt++; done_at = c; end
            if (!bad) begin
                checks++;
                if (a !== e) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL busy_start_cycle %0d got %h expected %h", c, a, e);
                end
            end
        end
        start_a = 1'b0;
        checks++;
        if (done_cnt != 1 || done_at != 20492) begin
            errors++;
            $display("[TB] FAIL busy_start_done got %0d pulses at %0d expected 1 at 20492", done_cnt, done_at);
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t a, e;
        bit   bad = 1'b0;
        int   done_cnt = 0;
        start_a = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            a = obs_a();
            e = model(c, DBA, OCA, PXA, RLA, MLA);
            if (!e.out_valid) begin a.out_pixel = '0; a.out_group = '0; end
            if (!bad) begin
                checks++;
                if (a !== e) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL pre_reset_cycle %0d got %h expected %h", c, a, e);
                end
            end
        end
        rst_a = 1'b1;
        @(negedge clk);
        a = obs_a();
        rst_a = 1'b0;
        checks++;
        if (a !== '0) begin errors++; $display("[TB] FAIL mid_reset_clear got %h expected 0", a); end
        bad = 1'b0;
        repeat ($urandom_range(10, 30)) begin
            @(negedge clk);
            a = obs_a();
            done_cnt += int'(a.done);
            if (!bad) begin
                checks++;
                if (a !== '0) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL post_reset_idle got %h expected 0", a);
                end
            end
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("[TB] FAIL reset_no_done got %0d expected 0", done_cnt); end
        bad = 1'b0;
        start_a = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            a = obs_a();
            e = model(c, DBA, OCA, PXA, RLA, MLA);
            if (!e.out_valid) begin a.out_pixel = '0; a.out_group = '0; end
            if (!bad) begin
                checks++;
                if (a !== e) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL restart_cycle %0d got %h expected %h", c, a, e);
                end
            end
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic test_single_beat();
        obs_t a, e;
        bit   bad = 1'b0;
        int   out_cnt = 0, rst_cnt = 0, done_at = -1;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start_b = 1'b1;
        for (int c = 1; c <= NB + RLB + MLB + 4; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            a = obs_b();
            e = model(c, DBB, OCB, PXB, RLB, MLB);
            if (!e.out_valid) begin a.out_pixel = '0; a.out_group = '0; end
            out_cnt += int'(a.out_valid);
            rst_cnt += int'(a.adder_rst && a.in_valid);
            if (a.done) done_at = c;
            if (!bad) begin
                checks++;
                if (a !== e) begin
                    errors++; bad = 1'b1;
                    $display("[TB] FAIL single_beat_cycle %0d got %h expected %h", c, a, e);
                end
            end
        end
        checks++;
        if (out_cnt != 6 || rst_cnt != 6) begin
            errors++;
            $display("[TB] FAIL single_beat_counts got out=%0d clr=%0d expected 6/6", out_cnt, rst_cnt);
        end
        checks++;
        if (done_at != 18) begin errors++; $display("[TB] FAIL single_beat_done got %0d expected 18", done_at); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_start_ignored();
        test_reset_mid_run();
        test_single_beat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
